mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage. Consumes the outputs of the EX/MEM pipeline register and produces the inputs of the MEM/WB register.
- Performs scalar and vector data-memory accesses over a narrow handshaked memory port. A 192-bit vector is serialized into 3 x 64-bit beats.
- Asserts stall to freeze the upstream pipeline while an access is in flight. Non-memory ops pass through registered.

Parameters:
- VEC_W, 192, vector/datapath width
- BEAT_W, 64, memory port data width
- BEATS, VEC_W/BEAT_W (3), beats per vector access
- ADDR_W, 32, word address width

Ports:
- clk  in  1  clock; all flops update on rising edge
- rst_n  in  1  asynchronous reset, active-low
- MemToReg_in  in  1  writeback selects memory result
- MemRead_in  in  1  load op
- MemWrite_in  in  1  store op
- VectorOp_in  in  1  1 = vector (BEATS beats), 0 = scalar (1 beat)
- RegSWrite_in  in  1  scalar regfile write enable
- RegVWrite_in  in  1  vector regfile write enable
- alu_in  in  VEC_W  ALU result; [ADDR_W-1:0] is the base word address for memory ops
- mux1_in  in  VEC_W  store data
- RR_in  in  4  destination register
- stall  out  1  freeze upstream stages (combinational from state/inputs)
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write beat
- mem_addr  out  ADDR_W  beat word address
- mem_wdata  out  BEAT_W  beat write data
- mem_rdata  in  BEAT_W  beat read data
- mem_ready  in  1  beat accepted/completed
- MemToReg_out, RegSWrite_out, RegVWrite_out  out  1 each  registered control to MEM/WB
- result_out  out  VEC_W  load data or pass-through ALU value
- RR_out  out  4  registered destination

Behaviour:
- Memory op = MemRead_in | MemWrite_in. If both are set, the op is treated as a store and the read is ignored.
- FSM states: IDLE, BUSY, DONE. Beat counter beat in 0..BEATS-1. Read buffer rbuf[VEC_W-1:0].
- IDLE:
  - Non-memory op: stall=0. Outputs load inputs at next edge (latency 1); result_out=alu_in.
  - Memory op: stall=1; next state BUSY, beat=0, rbuf=0. Outputs get a bubble (all write enables 0, result_out/RR_out hold).
- BUSY:
  - stall=1; mem_req=1; mem_we=store; mem_addr=base+beat (mod 2^ADDR_W); mem_wdata=mux1_in[beat*64 +: 64].
  - A beat completes in any cycle with mem_req && mem_ready (zero-wait ready is legal). On completion of a load beat, rbuf[beat*64 +: 64] <= mem_rdata.
  - Last beat is beat==0 for scalar, beat==BEATS-1 for vector. Last beat completes -> DONE; otherwise beat+1.
  - mem_ready low: hold state; addr/wdata/we stay stable.
  - Outputs keep the bubble.
- DONE:
  - stall=0; mem_req=0. Outputs load control fields from inputs.
  - result_out = rbuf if load (scalar: zero-extended low beat), else alu_in.
  - Next state IDLE unconditionally. Upstream advances on this cycle, so IDLE sees the next op.
- mem_req, mem_we, mem_addr, mem_wdata are 0 outside BUSY.
- Inputs must be held stable by upstream while stall=1.
- Reset (any time, including mid-BUSY): state=IDLE, beat=0, rbuf=0, all outputs 0, mem_req=0. The in-flight access is abandoned.
- Latency: non-mem 1 cycle; scalar mem with zero-wait memory 3 cycles; vector 5 cycles; plus 1 cycle per mem_ready-low cycle.

Optional Feature:
- Macro MEM_ACCESS_STATS_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] (increments each cycle stall=1, saturates at all-ones) and mem_beats[31:0] (increments per completed beat, wraps).
  - Both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, BUSY, DONE}
  - VEC_W, BEAT_W, BEATS, ADDR_W defaults
  - beat-index type
- One natural sub-module: mem_beat_sequencer (FSM + beat counter + handshake). The top holds rbuf and the output register.

Test Plan:
- ALU op, RegSWrite_in=1, alu_in=0x1234, RR_in=5 -> next edge result_out=0x1234, RR_out=5, RegSWrite_out=1, stall never high.
- Scalar load, base 0x10, mem_ready=1, mem_rdata=0xDEADBEEF -> one beat at addr 0x10; stall high 2 cycles; result_out=0x..00DEADBEEF zero-extended.
- Vector store, base 0x20, mux1_in={C,B,A} -> beats addr 0x20/0x21/0x22 carrying A/B/C with mem_we=1; no regfile write enables; stall high 4 cycles.
- Vector load with mem_ready low 2 cycles on beat 1 -> addr 0x21 held stable 3 cycles; final result_out = {beat2,beat1,beat0}; total stall 6 cycles.
- Vector access with base 0xFFFFFFFF -> addresses 0xFFFFFFFF, 0x0, 0x1 (wrap).
- rst_n pulsed low during beat 1 of vector load -> immediately mem_req=0, stall=0, outputs 0; after release, a new scalar load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, beat-index type and FSM state enum for the MEM stage.
package mem_pkg;
    localparam int VEC_W   = 192;
    localparam int BEAT_W  = 64;
    localparam int BEATS   = VEC_W / BEAT_W;
    localparam int ADDR_W  = 32;
    localparam int BEAT_IW = $clog2(BEATS);
    typedef logic [BEAT_IW-1:0] beat_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mem_beat_sequencer.sv
// mem_beat_sequencer: IDLE/BUSY/DONE FSM, beat counter and memory handshake.
// Ports: clk, rst_n (async, active-low); mem_op/vector describe the pending op;
// mem_ready is the memory handshake; state/beat/beat_done feed the datapath;
// stall freezes upstream; mem_req is the beat request valid.
module mem_beat_sequencer
    import mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   mem_op,
    input  logic   vector,
    input  logic   mem_ready,
    output state_t state,
    output beat_t  beat,
    output logic   beat_done,
    output logic   stall,
    output logic   mem_req
);
    state_t next_state;
    beat_t  next_beat;
    logic   last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= next_state;
            beat  <= next_beat;
        end
    end

    always_comb begin
        next_state = state;
        next_beat  = beat;
        mem_req    = state == BUSY;
        beat_done  = mem_req && mem_ready;
        last       = vector ? beat == beat_t'(BEATS - 1) : beat == '0;
        // gated by rst_n so an abandoned access releases upstream immediately
        stall      = rst_n && ((state == IDLE && mem_op) || state == BUSY);
        case (state)
            IDLE: if (mem_op) begin
                next_state = BUSY;
                next_beat  = '0;
            end
            BUSY: if (beat_done) begin
                if (last) next_state = DONE;
                else next_beat = beat + beat_t'(1);
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage serializing scalar/vector accesses into 64-bit beats.
// Ports: clk, rst_n (async, active-low); EX/MEM inputs (*_in, alu_in, mux1_in, RR_in);
// memory port (mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready);
// stall to upstream; registered MEM/WB outputs (*_out, result_out, RR_out).
// Optional MEM_ACCESS_STATS_EN adds stall_cycles and mem_beats counters.
module mem_access_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemToReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              VectorOp_in,
    input  logic              RegSWrite_in,
    input  logic              RegVWrite_in,
    input  logic [VEC_W-1:0]  alu_in,
    input  logic [VEC_W-1:0]  mux1_in,
    input  logic [3:0]        RR_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              MemToReg_out,
    output logic              RegSWrite_out,
    output logic              RegVWrite_out,
    output logic [VEC_W-1:0]  result_out,
    output logic [3:0]        RR_out
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       mem_beats
`endif
);
    state_t            state;
    beat_t             beat;
    logic              beat_done;
    logic              mem_op;
    logic              load;
    logic              capture;
    logic [VEC_W-1:0]  rbuf;

    // a store wins when both read and write are requested
    assign mem_op    = MemRead_in || MemWrite_in;
    assign load      = MemRead_in && !MemWrite_in;
    assign capture   = state == DONE || (state == IDLE && !mem_op);
    assign mem_we    = mem_req && MemWrite_in;
    assign mem_addr  = mem_req ? alu_in[ADDR_W-1:0] + ADDR_W'(beat) : '0;
    assign mem_wdata = mem_req ? mux1_in[beat*BEAT_W +: BEAT_W] : '0;

    mem_beat_sequencer u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_op    (mem_op),
        .vector    (VectorOp_in),
        .mem_ready (mem_ready),
        .state     (state),
        .beat      (beat),
        .beat_done (beat_done),
        .stall     (stall),
        .mem_req   (mem_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rbuf <= '0;
        else if (state == IDLE && mem_op) rbuf <= '0;
        else if (beat_done && load) rbuf[beat*BEAT_W +: BEAT_W] <= mem_rdata;
    end

    // bubble while an access is pending: write enables drop, data holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemToReg_out  <= 1'b0;
            RegSWrite_out <= 1'b0;
            RegVWrite_out <= 1'b0;
            result_out    <= '0;
            RR_out        <= '0;
        end else if (capture) begin
            MemToReg_out  <= MemToReg_in;
            RegSWrite_out <= RegSWrite_in;
            RegVWrite_out <= RegVWrite_in;
            RR_out        <= RR_in;
            result_out    <= (state == DONE && load) ?
                             (VectorOp_in ? rbuf : VEC_W'(rbuf[BEAT_W-1:0])) : alu_in;
        end else begin
            RegSWrite_out <= 1'b0;
            RegVWrite_out <= 1'b0;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            mem_beats    <= '0;
        end else begin
            if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
            if (beat_done) mem_beats <= mem_beats + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         MemToReg_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
    logic         VectorOp_in = 1'b0, RegSWrite_in = 1'b0, RegVWrite_in = 1'b0;
    logic [191:0] alu_in = '0, mux1_in = '0;
    logic [3:0]   RR_in = '0;
    logic         stall, mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         MemToReg_out, RegSWrite_out, RegVWrite_out;
    logic [191:0] result_out;
    logic [3:0]   RR_out;
`ifdef MEM_ACCESS_STATS_EN
    logic [31:0]  stall_cycles, mem_beats;
`endif
    int errors = 0;
    int checks = 0;

    localparam logic [63:0] A  = 64'hAAAA0000AAAA0001;
    localparam logic [63:0] B  = 64'hBBBB0000BBBB0002;
    localparam logic [63:0] C  = 64'hCCCC0000CCCC0003;
    localparam logic [63:0] D0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D2 = 64'h99AABBCCDDEEFF00;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemToReg_in   (MemToReg_in),
        .MemRead_in    (MemRead_in),
        .MemWrite_in   (MemWrite_in),
        .VectorOp_in   (VectorOp_in),
        .RegSWrite_in  (RegSWrite_in),
        .RegVWrite_in  (RegVWrite_in),
        .alu_in        (alu_in),
        .mux1_in       (mux1_in),
        .RR_in         (RR_in),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .MemToReg_out  (MemToReg_out),
        .RegSWrite_out (RegSWrite_out),
        .RegVWrite_out (RegVWrite_out),
        .result_out    (result_out),
        .RR_out        (RR_out)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .mem_beats     (mem_beats)
`endif
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic mt, input logic mr, input logic mw, input logic v,
                          input logic sw, input logic vw, input logic [191:0] alu,
                          input logic [191:0] mux, input logic [3:0] rr);
        MemToReg_in = mt; MemRead_in = mr; MemWrite_in = mw; VectorOp_in = v;
        RegSWrite_in = sw; RegVWrite_in = vw; alu_in = alu; mux1_in = mux; RR_in = rr;
    endtask

    task automatic nop;
        set_op(0, 0, 0, 0, 0, 0, '0, '0, 4'd0);
    endtask

    initial begin
        step;
        step;
        chk("rst_result", result_out, '0);
        chk("rst_rr", {188'd0, RR_out}, '0);
        chk("rst_stall", {191'd0, stall}, '0);
        chk("rst_req", {191'd0, mem_req}, '0);
        rst_n = 1'b1;
        step;

        // ALU pass-through
        set_op(0, 0, 0, 0, 1, 0, 192'h1234, '0, 4'd5);
        #1;
        chk("alu_stall", {191'd0, stall}, '0);
        step;
        chk("alu_result", result_out, 192'h1234);
        chk("alu_rr", {188'd0, RR_out}, 192'd5);
        chk("alu_sw", {191'd0, RegSWrite_out}, 192'd1);
        chk("alu_stall2", {191'd0, stall}, '0);

        // scalar load, zero-wait
        set_op(1, 1, 0, 0, 1, 0, 192'h10, '0, 4'd3);
        mem_ready = 1'b1;
        mem_rdata = 64'hDEADBEEF;
        #1;
        chk("sld_idle_stall", {191'd0, stall}, 192'd1);
        chk("sld_idle_req", {191'd0, mem_req}, '0);
        step;
        chk("sld_busy_stall", {191'd0, stall}, 192'd1);
        chk("sld_busy_req", {191'd0, mem_req}, 192'd1);
        chk("sld_busy_we", {191'd0, mem_we}, '0);
        chk("sld_busy_addr", {160'd0, mem_addr}, 192'h10);
        chk("sld_bubble_sw", {191'd0, RegSWrite_out}, '0);
        chk("sld_hold_result", result_out, 192'h1234);
        chk("sld_hold_rr", {188'd0, RR_out}, 192'd5);
        step;
        chk("sld_done_stall", {191'd0, stall}, '0);
        chk("sld_done_req", {191'd0, mem_req}, '0);
        step;
        nop;
        chk("sld_result", result_out, 192'hDEADBEEF);
        chk("sld_rr", {188'd0, RR_out}, 192'd3);
        chk("sld_sw", {191'd0, RegSWrite_out}, 192'd1);
        chk("sld_mtr", {191'd0, MemToReg_out}, 192'd1);
        step;

        // vector store
        set_op(0, 0, 1, 1, 0, 0, 192'h20, {C, B, A}, 4'd1);
        #1;
        chk("vst_idle_stall", {191'd0, stall}, 192'd1);
        step;
        chk("vst_b0_addr", {160'd0, mem_addr}, 192'h20);
        chk("vst_b0_data", {128'd0, mem_wdata}, {128'd0, A});
        chk("vst_b0_we", {191'd0, mem_we}, 192'd1);
        chk("vst_b0_stall", {191'd0, stall}, 192'd1);
        step;
        chk("vst_b1_addr", {160'd0, mem_addr}, 192'h21);
        chk("vst_b1_data", {128'd0, mem_wdata}, {128'd0, B});
        step;
        chk("vst_b2_addr", {160'd0, mem_addr}, 192'h22);
        chk("vst_b2_data", {128'd0, mem_wdata}, {128'd0, C});
        chk("vst_b2_stall", {191'd0, stall}, 192'd1);
        step;
        chk("vst_done_stall", {191'd0, stall}, '0);
        chk("vst_done_we", {191'd0, mem_we}, '0);
        chk("vst_done_wdata", {128'd0, mem_wdata}, '0);
        step;
        nop;
        chk("vst_sw", {191'd0, RegSWrite_out}, '0);
        chk("vst_vw", {191'd0, RegVWrite_out}, '0);
        chk("vst_result", result_out, 192'h20);
        step;

        // vector load, beat 1 waits two cycles
        set_op(1, 1, 0, 1, 0, 1, 192'h40, '0, 4'd7);
        #1;
        chk("vld_idle_stall", {191'd0, stall}, 192'd1);
        step;
        mem_rdata = D0;
        chk("vld_b0_addr", {160'd0, mem_addr}, 192'h40);
        step;
        mem_ready = 1'b0;
        mem_rdata = 64'hBAD0BAD0BAD0BAD0;
        chk("vld_b1_addr_a", {160'd0, mem_addr}, 192'h41);
        step;
        chk("vld_b1_addr_b", {160'd0, mem_addr}, 192'h41);
        chk("vld_b1_stall", {191'd0, stall}, 192'd1);
        step;
        mem_ready = 1'b1;
        mem_rdata = D1;
        chk("vld_b1_addr_c", {160'd0, mem_addr}, 192'h41);
        step;
        mem_rdata = D2;
        chk("vld_b2_addr", {160'd0, mem_addr}, 192'h42);
        chk("vld_b2_stall", {191'd0, stall}, 192'd1);
        step;
        chk("vld_done_stall", {191'd0, stall}, '0);
        step;
        nop;
        chk("vld_result", result_out, {D2, D1, D0});
        chk("vld_vw", {191'd0, RegVWrite_out}, 192'd1);
        chk("vld_rr", {188'd0, RR_out}, 192'd7);
        step;

        // address wrap
        set_op(0, 0, 1, 1, 0, 0, 192'hFFFFFFFF, {C, B, A}, 4'd0);
        step;
        chk("wrap_b0", {160'd0, mem_addr}, 192'hFFFFFFFF);
        step;
        chk("wrap_b1", {160'd0, mem_addr}, 192'h0);
        step;
        chk("wrap_b2", {160'd0, mem_addr}, 192'h1);
        step;
        step;
        nop;
        step;

        // reset in the middle of a vector load
        set_op(1, 1, 0, 1, 0, 1, 192'h50, '0, 4'd9);
        step;
        step;
        mem_ready = 1'b0;
        #1;
        chk("rmid_addr", {160'd0, mem_addr}, 192'h51);
        rst_n = 1'b0;
        #1;
        chk("rmid_req", {191'd0, mem_req}, '0);
        chk("rmid_stall", {191'd0, stall}, '0);
        chk("rmid_result", result_out, '0);
        chk("rmid_rr", {188'd0, RR_out}, '0);
        chk("rmid_vw", {191'd0, RegVWrite_out}, '0);
        step;
        set_op(0, 1, 0, 0, 1, 0, 192'h60, '0, 4'd2);
        mem_ready = 1'b1;
        mem_rdata = 64'hCAFEF00D;
        #1;
        rst_n = 1'b1;
        #1;
        chk("rpost_idle_stall", {191'd0, stall}, 192'd1);
        step;
        chk("rpost_addr", {160'd0, mem_addr}, 192'h60);
        step;
        chk("rpost_done_stall", {191'd0, stall}, '0);
        step;
        nop;
        chk("rpost_result", result_out, 192'hCAFEF00D);
        chk("rpost_rr", {188'd0, RR_out}, 192'd2);
        chk("rpost_sw", {191'd0, RegSWrite_out}, 192'd1);
        step;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
